// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequence/decode unit: a Moore FSM that steps the bus datapath through fetch, decode and execute.
// Optional: define SLC3_PAUSE_OP_EN to build the PAUSE1/PAUSE2 states for opcode 1101 (otherwise 1101 is a NOP).
module slc3_isdu #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S00, S22, S12,
    S04, S21, S06, S25, S27, S07, S23, S16
`ifdef SLC3_PAUSE_OP_EN
    , PAUSE1, PAUSE2
`endif
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  localparam ctrl_t      CTRL_IDLE = '{mem_oe: 1'b1, mem_we: 1'b1, default: '0};
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       mem_done;
  ctrl_t      ctrl;

  assign mem_done = (wait_cnt == WAIT_LAST);

  // Control word for a state; IR_5/IR_11 are stable once IR has been loaded in S35.
  function automatic ctrl_t decode(state_t s, logic ir5, logic ir11);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        c.pcmux   = 2'b00;
      end
      S33, S25: begin
        c.mem_oe = 1'b0;
        c.ld_mdr = 1'b1;
      end
      S35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S32: c.ld_ben = 1'b1;
      S01, S05: begin
        c.sr1mux   = 1'b1;
        c.sr2mux   = ir5;
        c.aluk     = (s == S05) ? 2'b01 : 2'b00;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S09: begin
        c.sr1mux   = 1'b1;
        c.aluk     = 2'b10;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S22: begin
        c.addr1mux = 1'b0;
        c.addr2mux = 2'b10;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S12: begin
        c.sr1mux   = 1'b1;
        c.addr1mux = 1'b1;
        c.addr2mux = 2'b00;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S04: begin
        c.drmux   = 1'b1;
        c.gate_pc = 1'b1;
        c.ld_reg  = 1'b1;
      end
      S21: begin
        // JSR adds off11 to PC; JSRR jumps through the base register like JMP.
        c.sr1mux   = !ir11;
        c.addr1mux = !ir11;
        c.addr2mux = ir11 ? 2'b11 : 2'b00;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S06, S07: begin
        c.sr1mux      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = 2'b01;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      S27: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S23: begin
        c.sr1mux   = 1'b0;
        c.aluk     = 2'b11;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      S16: c.mem_we = 1'b0;
`ifdef SLC3_PAUSE_OP_EN
      PAUSE1: c.ld_led = 1'b1;
`endif
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      HALTED: if (Run) state_nxt = S18;
      S18:    state_nxt = S33;
      S33: begin
        if (mem_done) state_nxt = S35;
        else          wait_nxt  = wait_cnt + 4'd1;
      end
      S35:    state_nxt = S32;
      S32: begin
        case (Opcode)
          4'b0001: state_nxt = S01;
          4'b0101: state_nxt = S05;
          4'b1001: state_nxt = S09;
          4'b0000: state_nxt = S00;
          4'b1100: state_nxt = S12;
          4'b0100: state_nxt = S04;
          4'b0110: state_nxt = S06;
          4'b0111: state_nxt = S07;
`ifdef SLC3_PAUSE_OP_EN
          4'b1101: state_nxt = PAUSE1;
`endif
          default: state_nxt = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S27: state_nxt = S18;
      S00:    state_nxt = BEN ? S22 : S18;
      S04:    state_nxt = S21;
      S06:    state_nxt = S25;
      S25: begin
        if (mem_done) state_nxt = S27;
        else          wait_nxt  = wait_cnt + 4'd1;
      end
      S07:    state_nxt = S23;
      S23:    state_nxt = S16;
      S16: begin
        if (mem_done) state_nxt = S18;
        else          wait_nxt  = wait_cnt + 4'd1;
      end
`ifdef SLC3_PAUSE_OP_EN
      // Two-step handshake: a held Continue releases only one pause.
      PAUSE1: if (Continue)  state_nxt = PAUSE2;
      PAUSE2: if (!Continue) state_nxt = S18;
`endif
      default: state_nxt = HALTED;
    endcase
  end

`ifndef SLC3_PAUSE_OP_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // Outputs are registered from the next state, giving the Moore decode of the current state glitch-free.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
      ctrl     <= CTRL_IDLE;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      ctrl     <= decode(state_nxt, IR_5, IR_11);
    end
  end

  assign LD_MAR     = ctrl.ld_mar;
  assign LD_MDR     = ctrl.ld_mdr;
  assign LD_IR      = ctrl.ld_ir;
  assign LD_BEN     = ctrl.ld_ben;
  assign LD_CC      = ctrl.ld_cc;
  assign LD_REG     = ctrl.ld_reg;
  assign LD_PC      = ctrl.ld_pc;
  assign LD_LED     = ctrl.ld_led;
  assign GatePC     = ctrl.gate_pc;
  assign GateMDR    = ctrl.gate_mdr;
  assign GateALU    = ctrl.gate_alu;
  assign GateMARMUX = ctrl.gate_marmux;
  assign PCMUX      = ctrl.pcmux;
  assign DRMUX      = ctrl.drmux;
  assign SR1MUX     = ctrl.sr1mux;
  assign SR2MUX     = ctrl.sr2mux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign ALUK       = ctrl.aluk;
  assign Mem_OE     = ctrl.mem_oe;
  assign Mem_WE     = ctrl.mem_we;

endmodule

// File: tb/tb_slc3_isdu.sv
// Self-checking bench for slc3_isdu: per-cycle control-word vectors plus hand-written fetch-latency and pause sequences.
module tb_slc3_isdu;

  localparam int unsigned MEM_WAIT = 3;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX, ALUK;
  logic       Mem_OE, Mem_WE;

  slc3_isdu #(.MEM_WAIT(MEM_WAIT)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_oe, mem_we;
  } sig_t;

  typedef enum {
    T_HALT, T_S18, T_MEMRD, T_S35, T_S32, T_ADD_IMM, T_AND_REG, T_NOT, T_S00, T_S22,
    T_JMP, T_JSR, T_S04, T_ADDR_MAR, T_S27, T_S23, T_MEMWR, T_PAUSE1, T_PAUSE2
  } tag_t;

  typedef struct {
    logic       rst, run, cont;
    logic [3:0] op;
    logic       ir5, ir11, ben;
    tag_t       exp;
  } vec_t;

  sig_t act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected control word for each observable state, written straight from the state table.
  function automatic sig_t expect_sig(tag_t t);
    sig_t s;
    s = '0;
    s.mem_oe = 1'b1;
    s.mem_we = 1'b1;
    case (t)
      T_S18:      begin s.gate_pc = 1; s.ld_mar = 1; s.ld_pc = 1; end
      T_MEMRD:    begin s.mem_oe = 0; s.ld_mdr = 1; end
      T_S35:      begin s.gate_mdr = 1; s.ld_ir = 1; end
      T_S32:      s.ld_ben = 1;
      T_ADD_IMM:  begin s.sr1mux = 1; s.sr2mux = 1; s.aluk = 2'b00; s.gate_alu = 1; s.ld_reg = 1; s.ld_cc = 1; end
      T_AND_REG:  begin s.sr1mux = 1; s.sr2mux = 0; s.aluk = 2'b01; s.gate_alu = 1; s.ld_reg = 1; s.ld_cc = 1; end
      T_NOT:      begin s.sr1mux = 1; s.aluk = 2'b10; s.gate_alu = 1; s.ld_reg = 1; s.ld_cc = 1; end
      T_S22:      begin s.addr2mux = 2'b10; s.pcmux = 2'b10; s.ld_pc = 1; end
      T_JMP:      begin s.sr1mux = 1; s.addr1mux = 1; s.addr2mux = 2'b00; s.pcmux = 2'b10; s.ld_pc = 1; end
      T_JSR:      begin s.addr1mux = 0; s.addr2mux = 2'b11; s.pcmux = 2'b10; s.ld_pc = 1; end
      T_S04:      begin s.drmux = 1; s.gate_pc = 1; s.ld_reg = 1; end
      T_ADDR_MAR: begin s.sr1mux = 1; s.addr1mux = 1; s.addr2mux = 2'b01; s.gate_marmux = 1; s.ld_mar = 1; end
      T_S27:      begin s.gate_mdr = 1; s.ld_reg = 1; s.ld_cc = 1; end
      T_S23:      begin s.aluk = 2'b11; s.gate_alu = 1; s.ld_mdr = 1; end
      T_MEMWR:    s.mem_we = 0;
      T_PAUSE1:   s.ld_led = 1;
      default:    ;
    endcase
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic run, input logic cont, input logic [3:0] op,
                     input logic ir5, input logic ir11, input logic ben, input tag_t e);
    vecs.push_back('{rst, run, cont, op, ir5, ir11, ben, e});
  endtask

  // S18 -> S33 x MEM_WAIT -> S35 -> S32 with the instruction's fields held on the inputs.
  task automatic add_fetch(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    for (int k = 0; k < int'(MEM_WAIT); k++) add(0, 0, 0, op, ir5, ir11, ben, T_MEMRD);
    add(0, 0, 0, op, ir5, ir11, ben, T_S35);
    add(0, 0, 0, op, ir5, ir11, ben, T_S32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_edges;
    int n_oe;

    Reset = 1; Run = 1; Continue = 0; Opcode = '0; IR_5 = 0; IR_11 = 0; BEN = 0;

    // Reset held with Run=1, then release into fetch.
    add(1, 1, 0, 4'b0000, 0, 0, 0, T_HALT);
    add(1, 1, 0, 4'b0000, 0, 0, 0, T_HALT);
    add(0, 1, 0, 4'b0001, 1, 0, 0, T_S18);
    // ADD immediate
    add_fetch(4'b0001, 1, 0, 0);
    add(0, 0, 0, 4'b0001, 1, 0, 0, T_ADD_IMM);
    add(0, 0, 0, 4'b0001, 1, 0, 0, T_S18);
    // BR taken
    add_fetch(4'b0000, 0, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0, 1, T_S00);
    add(0, 0, 0, 4'b0000, 0, 0, 1, T_S22);
    add(0, 0, 0, 4'b0000, 0, 0, 1, T_S18);
    // BR not taken
    add_fetch(4'b0000, 0, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 0, T_S00);
    add(0, 0, 0, 4'b0000, 0, 0, 0, T_S18);
    // ST complete
    add_fetch(4'b0111, 0, 0, 0);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_ADDR_MAR);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_S23);
    for (int k = 0; k < int'(MEM_WAIT); k++) add(0, 0, 0, 4'b0111, 0, 0, 0, T_MEMWR);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_S18);
    // ST aborted by reset during the second write cycle
    add_fetch(4'b0111, 0, 0, 0);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_ADDR_MAR);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_S23);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_MEMWR);
    add(0, 0, 0, 4'b0111, 0, 0, 0, T_MEMWR);
    add(1, 0, 0, 4'b0111, 0, 0, 0, T_HALT);
    add(0, 0, 0, 4'b0110, 0, 0, 0, T_HALT);
    add(0, 1, 0, 4'b0110, 0, 0, 0, T_S18);
    // LDR
    add_fetch(4'b0110, 0, 0, 0);
    add(0, 0, 0, 4'b0110, 0, 0, 0, T_ADDR_MAR);
    for (int k = 0; k < int'(MEM_WAIT); k++) add(0, 0, 0, 4'b0110, 0, 0, 0, T_MEMRD);
    add(0, 0, 0, 4'b0110, 0, 0, 0, T_S27);
    add(0, 0, 0, 4'b0110, 0, 0, 0, T_S18);
    // Illegal opcode executes as NOP
    add_fetch(4'b0011, 0, 0, 0);
    add(0, 0, 0, 4'b0011, 0, 0, 0, T_S18);
    // NOT
    add_fetch(4'b1001, 0, 0, 0);
    add(0, 0, 0, 4'b1001, 0, 0, 0, T_NOT);
    add(0, 0, 0, 4'b1001, 0, 0, 0, T_S18);
    // AND register form
    add_fetch(4'b0101, 0, 0, 0);
    add(0, 0, 0, 4'b0101, 0, 0, 0, T_AND_REG);
    add(0, 0, 0, 4'b0101, 0, 0, 0, T_S18);
    // JMP
    add_fetch(4'b1100, 0, 0, 0);
    add(0, 0, 0, 4'b1100, 0, 0, 0, T_JMP);
    add(0, 0, 0, 4'b1100, 0, 0, 0, T_S18);
    // JSR (offset form)
    add_fetch(4'b0100, 0, 1, 0);
    add(0, 0, 0, 4'b0100, 0, 1, 0, T_S04);
    add(0, 0, 0, 4'b0100, 0, 1, 0, T_JSR);
    add(0, 0, 0, 4'b0100, 0, 1, 0, T_S18);
    // JSRR (register form)
    add_fetch(4'b0100, 0, 0, 0);
    add(0, 0, 0, 4'b0100, 0, 0, 0, T_S04);
    add(0, 0, 0, 4'b0100, 0, 0, 0, T_JMP);
    add(0, 0, 0, 4'b0100, 0, 0, 0, T_S18);

    foreach (vecs[i]) begin
      Reset = vecs[i].rst; Run = vecs[i].run; Continue = vecs[i].cont;
      Opcode = vecs[i].op; IR_5 = vecs[i].ir5; IR_11 = vecs[i].ir11; BEN = vecs[i].ben;
      step();
      check($sformatf("vec%0d_%s", i, vecs[i].exp.name()), 32'(act), 32'(expect_sig(vecs[i].exp)));
      check($sformatf("vec%0d_gates", i),
            32'($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 32'd1);
    end

    // Fetch latency from reset release: one edge into S18, then MEM_WAIT+2 edges to S32.
    Reset = 1; Run = 0; Continue = 0;
    step();
    check("reset_again", 32'(act), 32'(expect_sig(T_HALT)));
    Reset = 0; Run = 1; Opcode = 4'b1101; IR_5 = 0; IR_11 = 0; BEN = 0;
    n_edges = 0;
    n_oe    = 0;
    while (n_edges < 40) begin
      step();
      n_edges++;
      if (!Mem_OE) n_oe++;
      if (LD_BEN) break;
    end
    Run = 0;
    check("fetch_latency_edges", 32'(n_edges), 32'(MEM_WAIT + 3));
    check("fetch_mem_oe_cycles", 32'(n_oe), 32'(MEM_WAIT));

`ifdef SLC3_PAUSE_OP_EN
    Continue = 0;
    step();
    check("pause1_enter", 32'(act), 32'(expect_sig(T_PAUSE1)));
    step();
    check("pause1_hold", 32'(act), 32'(expect_sig(T_PAUSE1)));
    Continue = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("pause2_held%0d", k), 32'(act), 32'(expect_sig(T_PAUSE2)));
    end
    Continue = 0;
    step();
    check("pause_release", 32'(act), 32'(expect_sig(T_S18)));
    step();
    check("pause_after", 32'(act), 32'(expect_sig(T_MEMRD)));
`else
    Continue = 1;
    step();
    check("op1101_nop", 32'(act), 32'(expect_sig(T_S18)));
    step();
    check("op1101_after", 32'(act), 32'(expect_sig(T_MEMRD)));
    Continue = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
